// File: rtl/fnv_pkg.sv
// Shared constants for the FNV-1a 32-bit hasher: hash and length widths,
// offset basis, prime, and the saturating length increment.
package fnv_pkg;

    localparam int HASH_W = 32;
    localparam int LEN_W  = 16;

    localparam logic [HASH_W-1:0] FNV_OFFSET_BASIS_32 = 32'h811C9DC5;
    localparam logic [HASH_W-1:0] FNV_PRIME_32        = 32'h01000193;

    localparam logic [LEN_W-1:0] LEN_MAX = {LEN_W{1'b1}};

    // Message lengths stick at all-ones rather than wrapping.
    function automatic logic [LEN_W-1:0] satInc(input logic [LEN_W-1:0] len);
        return (len == LEN_MAX) ? LEN_MAX : len + 1'b1;
    endfunction

endpackage

// File: rtl/fnv1a_step.sv
// One FNV-1a byte step: xor the byte into the low bits, then multiply by the prime.
module fnv1a_step
    import fnv_pkg::*;
#(
    parameter logic [HASH_W-1:0] PRIME = FNV_PRIME_32
) (
    input  logic [HASH_W-1:0] i_hash,
    input  logic [7:0]        i_byte,
    output logic [HASH_W-1:0] o_hash
);

    logic [HASH_W-1:0] w_mixed;

    assign w_mixed = i_hash ^ {{(HASH_W-8){1'b0}}, i_byte};

    // The standard prime 0x01000193 reduces to shifts: 2^24 + 2^8 + 2^7 + 2^4 + 2^1 + 1.
    generate
        if (PRIME == FNV_PRIME_32) begin : g_shiftAdd
            assign o_hash = (w_mixed << 24) + (w_mixed << 8) + (w_mixed << 7)
                          + (w_mixed << 4) + (w_mixed << 1) + w_mixed;
        end else begin : g_multiply
            assign o_hash = w_mixed * PRIME;
        end
    endgenerate

endmodule

// File: rtl/fnv_hash_arbiter.sv
// Round-robin arbiter sharing one FNV-1a step between two byte-stream requesters,
// each with its own running hash and length; emits a digest record on the last byte.
module fnv_hash_arbiter
    import fnv_pkg::*;
#(
    parameter logic [HASH_W-1:0] OFFSET_BASIS = FNV_OFFSET_BASIS_32,
    parameter logic [HASH_W-1:0] FNV_PRIME    = FNV_PRIME_32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    input  logic [15:0]       req_data,
    input  logic [1:0]        req_last,
    input  logic [1:0]        req_clear,
    output logic [1:0]        req_ready,
    output logic              dig_valid,
    output logic              dig_id,
    output logic [HASH_W-1:0] digest,
    output logic [LEN_W-1:0]  dig_len
);

    logic [HASH_W-1:0] r_hash [2];
    logic [LEN_W-1:0]  r_len  [2];
    logic              r_ptr;
    logic              r_digValid;
    logic              r_digId;
    logic [HASH_W-1:0] r_digest;
    logic [LEN_W-1:0]  r_digLen;

    logic [1:0]        w_elig;
    logic              w_grantAny;
    logic              w_grantId;
    logic [7:0]        w_byte;
    logic              w_last;
    logic [HASH_W-1:0] w_stepOut;
    logic [LEN_W-1:0]  w_lenNext;

    assign w_elig = req_valid & ~req_clear;

    // The pointer side wins when eligible; otherwise the other side may take the slot.
    always_comb begin
        w_grantAny = 1'b0;
        w_grantId  = r_ptr;
        if (w_elig[r_ptr]) begin
            w_grantAny = 1'b1;
            w_grantId  = r_ptr;
        end else if (w_elig[~r_ptr]) begin
            w_grantAny = 1'b1;
            w_grantId  = ~r_ptr;
        end
    end

    assign req_ready = w_grantAny ? (w_grantId ? 2'b10 : 2'b01) : 2'b00;
    assign w_byte    = w_grantId ? req_data[15:8] : req_data[7:0];
    assign w_last    = w_grantId ? req_last[1] : req_last[0];
    assign w_lenNext = satInc(r_len[w_grantId]);

    fnv1a_step #(
        .PRIME (FNV_PRIME)
    ) u_step (
        .i_hash (r_hash[w_grantId]),
        .i_byte (w_byte),
        .o_hash (w_stepOut)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                r_hash[i] <= OFFSET_BASIS;
                r_len[i]  <= '0;
            end
            r_ptr      <= 1'b0;
            r_digValid <= 1'b0;
            r_digId    <= 1'b0;
            r_digest   <= '0;
            r_digLen   <= '0;
        end else begin
            r_digValid <= 1'b0;
            if (w_grantAny) begin
                r_ptr <= ~w_grantId;
                if (w_last) begin
                    r_digValid <= 1'b1;
                    r_digId    <= w_grantId;
                    r_digest   <= w_stepOut;
                    r_digLen   <= w_lenNext;
                end
            end
            // A clear and a finished message both leave the requester ready for a fresh start.
            for (int i = 0; i < 2; i++) begin
                if (req_clear[i] || (w_grantAny && w_grantId == 1'(i) && w_last)) begin
                    r_hash[i] <= OFFSET_BASIS;
                    r_len[i]  <= '0;
                end else if (w_grantAny && w_grantId == 1'(i)) begin
                    r_hash[i] <= w_stepOut;
                    r_len[i]  <= w_lenNext;
                end
            end
        end
    end

    assign dig_valid = r_digValid;
    assign dig_id    = r_digId;
    assign digest    = r_digest;
    assign dig_len   = r_digLen;

endmodule

// File: doc/fnv_hash_arbiter.md
# fnv_hash_arbiter

Shares one FNV-1a 32-bit byte-step datapath between two byte-stream requesters: the I2C slave byte path and the parallel `ui_in` strobe path of the hasher project. Each requester owns its own running hash and length counter. The arbiter grants one byte per cycle round-robin, updates that requester's hash, and emits a digest record when the requester marks its last byte. It sits between the front-end byte sources and the digest readout registers inside the user project.

## Interface
Parameters:
- `OFFSET_BASIS`, default 32'h811C9DC5, hash value after reset, clear or digest.
- `FNV_PRIME`, default 32'h01000193, multiplier for each byte step.

Ports:
- `clk`  in  1  single clock; all state is on its rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `req_valid`  in  2  per-requester byte valid.
- `req_data`  in  16  bytes; requester i uses bits [8i+7:8i].
- `req_last`  in  2  qualifies the byte as the final byte of the message.
- `req_clear`  in  2  level; aborts the message and restores `OFFSET_BASIS` and length 0.
- `req_ready`  out  2  grant and byte accept this cycle (one-hot or zero).
- `dig_valid`  out  1  one-cycle pulse, digest record valid.
- `dig_id`  out  1  requester index of the record.
- `digest`  out  32  final FNV-1a hash.
- `dig_len`  out  16  bytes in the message, saturating at 16'hFFFF.

## Operation
- State: `h[0..1]` 32b, `len[0..1]` 16b, round-robin pointer `ptr` 1b, registered digest outputs.
- Eligible(i) = `req_valid[i]` and not `req_clear[i]`.
- Grant: if Eligible(`ptr`), grant `ptr`; otherwise grant the other requester if eligible; otherwise no grant. `req_ready[i]` = grant(i), combinational from valid, clear and `ptr`. The bus has no other ready dependency.
- On grant to i, `ptr` becomes 1-i. With no grant, `ptr` holds.
- Accepted byte b for i, non-last: `h[i]` becomes ((`h[i]` ^ {24'b0,b}) * `FNV_PRIME`) mod 2^32. `len[i]` becomes `len[i]`+1, saturating.
- Accepted byte with last: compute the same step and the same saturating length. Present them as `digest` and `dig_len` with `dig_id`=i and `dig_valid`=1 on the next cycle. `h[i]` reloads `OFFSET_BASIS` and `len[i]` reloads 0.
- A zero-length message cannot be expressed. `req_last` always carries a byte.
- `req_clear[i]` reloads `h[i]` and `len[i]` every cycle it is high. It never touches the other requester or the digest outputs.
- Both requesters finishing in consecutive cycles gives back-to-back `dig_valid` pulses. There is no backpressure on the digest output; the consumer must capture on the pulse.

## Timing
- Reset values: `h`=`OFFSET_BASIS`, `len`=0, `ptr`=0, `dig_valid`=0, `dig_id`=0, `digest`=0, `dig_len`=0. `req_ready`=0 while no request is valid.
- Throughput: one byte per cycle total. With both requesters valid, grants alternate.
- Latency: a last byte accepted in cycle N gives `dig_valid` in cycle N+1. The requester may start a new message in N+1.
- `digest`, `dig_id` and `dig_len` hold their values after the pulse until the next record.
- Asserting `rst` mid-message discards all partial hashes immediately and drops any pending digest pulse.

## Structure
- Package `fnv_pkg`: `FNV_OFFSET_BASIS_32`, `FNV_PRIME_32`, the hash width and the length width. The parameter defaults come from it.
- Sub-module `fnv1a_step`: combinational, (h[31:0], b[7:0]) to h'[31:0]. The multiply is implemented as a shift-add: h·2^24 + h·0x193. It is instanced once and its input is muxed by the grant, which proves the datapath is shared.
- Estimated size: about 200 lines of RTL.

## Test plan
- Reset, then requester 0 sends single byte "a" (8'h61) with last -> next cycle `dig_valid`=1, `dig_id`=0, `digest`=32'hE40C292C, `dig_len`=1.
- Requester 1 sends "foobar" with last on "r", requester 0 idle -> six consecutive grants to 1, then `digest`=32'hBF9CF968, `dig_len`=6.
- Both requesters continuously valid, sending "foobar" and "foobar" -> `req_ready` alternates 01,10,… starting with 0. Two digests of 32'hBF9CF968 arrive in consecutive cycles, id 0 then 1.
- Requester 0 sends "foo", asserts `req_clear[0]` for one cycle, then sends "a"+last -> `digest`=32'hE40C292C, `dig_len`=1. Throughout, `req_ready[0]`=0 during the clear.
- `rst` pulsed after requester 1 sends "foo" -> all outputs return to reset values. A subsequent "a"+last on requester 1 gives 32'hE40C292C.
- 70000 bytes of 8'h00 then last on requester 0 -> `dig_len`=16'hFFFF; digest matches the reference model.
